restoring_divider: RTL and testbench
====================================

// Module: restoring_divider
// PURPOSE
//   Multi-cycle unsigned integer divider: the inverse of the ripple-carry adder datapath.
//   Computes quotient and remainder by restoring division, one quotient bit per clock.
//   Each step is a trial subtraction through a ripple-carry subtractor (A + ~B + 1).
//   Sits beside the adders as the arithmetic block for divide operations.
//   A start/done handshake drives it.
// PARAMETERS
//   WIDTH  4  operand, quotient and remainder width in bits (>= 2)
// PORTS
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous, active-high reset
//   start         in   1      request a division; sampled only in IDLE or DONE
//   dividend      in   WIDTH  unsigned dividend, sampled when start is accepted
//   divisor       in   WIDTH  unsigned divisor, sampled when start is accepted
//   busy          out  1      high while in CALC
//   done          out  1      one-cycle pulse: results are valid
//   quotient      out  WIDTH  result, held until the next accepted start
//   remainder     out  WIDTH  result, held until the next accepted start
//   div_by_zero   out  1      divisor was 0; valid with done, held like the results
// BEHAVIOUR
//   Reset: state=IDLE.
//     - busy, done, div_by_zero = 0; quotient, remainder = 0.
//     - rst wins over every other input. rst during CALC aborts the operation; no done pulse.
//   FSM states: IDLE, CALC, DONE.
//     - IDLE --start--> CALC, or DONE if divisor==0.
//     - CALC --after WIDTH steps--> DONE.
//     - DONE --start--> CALC or DONE (back-to-back accepted).
//     - DONE --no start--> IDLE.
//   Accept: start=1 at edge N, in IDLE or DONE.
//     - Latch dividend into shift reg Q and divisor into D; R = 0.
//     - Set step counter = WIDTH-1; busy=1 from edge N.
//     - start while busy is ignored; operands are not re-sampled.
//   Step, at each of edges N+1 .. N+WIDTH:
//     - T = {R, Q[WIDTH-1]}, WIDTH+1 bits.
//     - Subtract: {cout, diff} = T + ~{1'b0, D} + 1.
//     - cout=1 (no borrow): R = diff[WIDTH-1:0], shift 1 into Q LSB.
//     - cout=0: R = T[WIDTH-1:0], shift 0 into Q LSB.
//   Completion at edge N+WIDTH: state=DONE, busy=0, done=1.
//     - quotient=Q, remainder=R, div_by_zero=0.
//     - Latency: done is high in the cycle after edge N+WIDTH. done is exactly 1 cycle wide.
//   Divide by zero (divisor==0 at accept edge N):
//     - Skip CALC; at edge N go to DONE with done=1, div_by_zero=1.
//     - quotient = all ones; remainder = dividend; busy stays 0.
//   Outputs quotient, remainder and div_by_zero change only at a completion edge or at reset.
//   Invariant: dividend = quotient*divisor + remainder, and remainder < divisor.
// STRUCTURE
//   Package div_pkg:
//     - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
//     - function clog2-based counter width helper.
//   Sub-module rca_subtractor #(N = WIDTH+1):
//     - Ports a, b, diff, cout (cout=1 means no borrow).
//     - Ripple chain of full adders on a + ~b with carry-in 1.
//   Top: FSM, step counter, Q/R/D registers, output registers.
// TESTING
//   1. W=4, 11/3 -> done at cycle N+5; quotient=3, remainder=2, div_by_zero=0; busy high for 4 cycles.
//   2. 15/1 -> quotient=15, remainder=0.
//      5/7 -> quotient=0, remainder=5.
//      0/9 -> quotient=0, remainder=0.
//   3. 9/0 -> done in the cycle after edge N; div_by_zero=1, quotient=4'hF, remainder=9; busy never high.
//   4. Start 12/5, then pulse start with 1/1 at edge N+2:
//      - second start is ignored; result quotient=2, remainder=2;
//      - exactly one done pulse.
//   5. Assert rst at edge N+2 of 13/4:
//      - all outputs return to 0, state IDLE, no done pulse;
//      - a following 13/4 gives quotient=3, remainder=1.
//   6. Back-to-back: start 14/3, then start 7/2 in its DONE cycle:
//      - done pulses 5 cycles apart;
//      - results 4/2, then 3/1;
//      - exhaustive sweep of all 256 operand pairs checked against the reference-model invariant.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and counter sizing for the restoring divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/rca_subtractor.sv
// rca_subtractor: ripple-carry a - b computed as a + ~b + 1; cout=1 means no borrow.
module rca_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);
  logic c;
  always_comb begin
    c = 1'b1;
    diff = '0;
    for (int i = 0; i < N; i++) begin
      diff[i] = a[i] ^ ~b[i] ^ c;
      c = (a[i] & ~b[i]) | (c & (a[i] ^ ~b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: unsigned restoring division, one quotient bit per clock, start/done handshake.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_width(WIDTH);
  div_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH-1:0] q_step, r_step;
  logic done_q, done_d, dz_q, dz_d;
  logic [WIDTH:0] t, diff;
  logic cout, unused_msb;
  assign t = {r_q, q_q[WIDTH-1]};
  // diff only feeds R when there is no borrow, so its MSB is always zero then
  assign unused_msb = diff[WIDTH];
  rca_subtractor #(.N(WIDTH + 1)) u_sub (
    .a(t),
    .b({1'b0, d_q}),
    .diff(diff),
    .cout(cout)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    q_d = q_q;
    r_d = r_q;
    d_d = d_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dz_d = dz_q;
    done_d = 1'b0;
    q_step = {q_q[WIDTH-2:0], cout};
    r_step = cout ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    if (start && state_q != CALC) begin
      q_d = dividend;
      d_d = divisor;
      r_d = '0;
      cnt_d = CW'(WIDTH - 1);
      state_d = (divisor == '0) ? DONE : CALC;
      if (divisor == '0) begin
        done_d = 1'b1;
        quo_d = '1;
        rem_d = dividend;
        dz_d = 1'b1;
      end
    end else if (state_q == CALC) begin
      q_d = q_step;
      r_d = r_step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = DONE;
        done_d = 1'b1;
        quo_d = q_step;
        rem_d = r_step;
        dz_d = 1'b0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      r_q <= r_d;
      d_q <= d_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dz_q <= dz_d;
      done_q <= done_d;
    end
  end
  assign busy = (state_q == CALC);
  assign done = done_q;
  assign quotient = quo_q;
  assign remainder = rem_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: cycle-level arithmetic reference model plus directed and random stimulus.
module tb_restoring_divider;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int errs = 0, checks = 0;
  int left = 0, m_q = 0, m_r = 0, p_q = 0, p_r = 0, a_l = 0, b_l = 0;
  logic m_done = 1'b0, m_dz = 1'b0;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a started division finishes W clocks later with a/b and a%b
  always @(posedge clk) begin
    if (rst) begin
      left = 0;
      m_done = 1'b0;
      m_q = 0;
      m_r = 0;
      m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_done = 1'b1;
          m_q = p_q;
          m_r = p_r;
          m_dz = 1'b0;
        end
      end else if (start) begin
        a_l = dividend;
        b_l = divisor;
        if (divisor == 0) begin
          m_done = 1'b1;
          m_q = 2 ** W - 1;
          m_r = dividend;
          m_dz = 1'b1;
        end else begin
          left = W;
          p_q = dividend / divisor;
          p_r = dividend % divisor;
        end
      end
    end
    #1;
    chk("busy", busy, left > 0);
    chk("done", done, m_done);
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("div_by_zero", div_by_zero, m_dz);
    if (done && !div_by_zero)
      chk("invariant", (int'(quotient) * b_l + int'(remainder) == a_l) && (int'(remainder) < b_l), 1);
  end

  task automatic do_div(input int a, input int b, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    dividend = W'(a);
    divisor = W'(b);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done && lat < 20) begin
      bcnt += int'(busy);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!done) begin
      errs++;
      $display("FAIL timeout: no done for %0d/%0d after %0d cycles", a, b, lat);
    end
  endtask

  initial begin
    int lat, bcnt, dcnt, cq, cr;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_q", quotient, 0);
    chk("reset_r", remainder, 0);
    chk("reset_done", done, 0);
    // 11/3: done five negedges after the start was set up, busy for four
    do_div(11, 3, lat, bcnt);
    chk("t1_lat", lat, 5);
    chk("t1_busy_cycles", bcnt, 4);
    chk("t1_q", quotient, 3);
    chk("t1_r", remainder, 2);
    chk("t1_dz", div_by_zero, 0);
    do_div(15, 1, lat, bcnt);
    chk("t2a_q", quotient, 15);
    chk("t2a_r", remainder, 0);
    do_div(5, 7, lat, bcnt);
    chk("t2b_q", quotient, 0);
    chk("t2b_r", remainder, 5);
    do_div(0, 9, lat, bcnt);
    chk("t2c_q", quotient, 0);
    chk("t2c_r", remainder, 0);
    do_div(9, 0, lat, bcnt);
    chk("t3_lat", lat, 1);
    chk("t3_busy_cycles", bcnt, 0);
    chk("t3_dz", div_by_zero, 1);
    chk("t3_q", quotient, 15);
    chk("t3_r", remainder, 9);
    // 12/5 with a stray 1/1 start two edges later
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd12;
    divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd1;
    divisor = 4'd1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    cq = -1;
    cr = -1;
    repeat (8) begin
      if (done) begin
        dcnt++;
        cq = quotient;
        cr = remainder;
      end
      @(negedge clk);
    end
    chk("t4_done_pulses", dcnt, 1);
    chk("t4_q", cq, 2);
    chk("t4_r", cr, 2);
    // reset two edges into 13/4
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd13;
    divisor = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_q", quotient, 0);
    chk("t5_r", remainder, 0);
    chk("t5_busy", busy, 0);
    dcnt = 0;
    repeat (6) begin
      dcnt += int'(done);
      @(negedge clk);
    end
    chk("t5_no_done", dcnt, 0);
    do_div(13, 4, lat, bcnt);
    chk("t5_q2", quotient, 3);
    chk("t5_r2", remainder, 1);
    // back-to-back: second start issued in the DONE cycle of the first
    do_div(14, 3, lat, bcnt);
    chk("t6_q1", quotient, 4);
    chk("t6_r1", remainder, 2);
    start = 1'b1;
    dividend = 4'd7;
    divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_spacing", lat, 5);
    chk("t6_q2", quotient, 3);
    chk("t6_r2", remainder, 1);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_div(a, b, lat, bcnt);
    repeat (400) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      dividend = W'($urandom);
      divisor = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rst = ($urandom_range(0, 40) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (8) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
